// File: rtl/riscv_pkg.sv
// Shared core constants and types.
//   XLEN      : operand / register file data width
//   AW        : register address width
//   wb_port_t : writeback port bundle {we, waddr, wdata}, also used by the writeback stage
//   wb_hit()  : "does this write land on this source register" compare; x0 never matches
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } wb_port_t;

  // x0 is hard-wired to zero, so a write to it must never be forwarded.
  function automatic logic wb_hit(input logic we, input logic [AW-1:0] waddr,
                                  input logic [AW-1:0] rs);
    return we && (waddr == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/operand_resolve.sv
// Combinational per-operand resolver: x0 / last-write bypass / register file data.
// Ports:
//   rs        in  AW    source register index
//   rf_rdata  in  XLEN  register file read data for rs
//   lw_we, lw_waddr, lw_wdata  in  write that landed on the edge the read was sampled
//   val       out XLEN  resolved operand
//   hit       out 1     last write targets rs (rs != 0)
// Build option: OPFETCH_BYPASS_EN selects lw_wdata on a hit; otherwise the hit is
// only reported and the caller must re-read.
module operand_resolve
  import riscv_pkg::*;
(
  input  logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] rf_rdata,
  input  logic            lw_we,
  input  logic [AW-1:0]   lw_waddr,
  input  logic [XLEN-1:0] lw_wdata,
  output logic [XLEN-1:0] val,
  output logic            hit
);

  assign hit = wb_hit(lw_we, lw_waddr, rs);

`ifdef OPFETCH_BYPASS_EN
  always_comb begin
    val = rf_rdata;
    if (rs == '0)  val = '0;
    else if (hit)  val = lw_wdata;
  end
`else
  logic unused_lw_wdata;
  assign unused_lw_wdata = ^lw_wdata;

  always_comb begin
    val = rf_rdata;
    if (rs == '0) val = '0;
  end
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage between decode and execute.
// Drives the register file read ports (registered reads, 1-cycle latency), aligns the
// returned data with the instruction and resolves write/read hazards against the
// register file write port.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              decode handshake; in_rs1, in_rs2, in_payload
//   rf_raddr1/2, rf_rdata1/2       register file read ports
//   wb_we, wb_waddr, wb_wdata      snoop of the register file write port
//   out_valid/out_ready            execute handshake; out_rs1_val, out_rs2_val, out_payload
// Handshake: a transfer happens on a rising edge where valid && ready; a producer holds
// valid and data stable until that edge; ready may depend combinationally on the
// consumer's ready.
// Build option: OPFETCH_BYPASS_EN enables the last-write bypass; without it a hit on a
// PEND source stalls PEND one cycle so the register file can be re-read.
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int PW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [PW-1:0]   in_payload,
  output logic [AW-1:0]   rf_raddr1,
  output logic [AW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [PW-1:0]   out_payload
);

  // PEND slot: register file read in flight
  logic            pend_valid;
  logic [AW-1:0]   pend_rs1;
  logic [AW-1:0]   pend_rs2;
  logic [PW-1:0]   pend_payload;

  // OUT slot source indices, kept for the snoop
  logic [AW-1:0]   out_rs1;
  logic [AW-1:0]   out_rs2;

  // Write that committed on the most recent edge; the register file returned
  // pre-write data if the read shared that edge.
  wb_port_t        lw;

  logic            accepting;
  logic            pend_advances;
  logic            pend_hold;
  logic            hit1;
  logic            hit2;
  logic [XLEN-1:0] res1;
  logic [XLEN-1:0] res2;

  operand_resolve u_res1 (
    .rs       (pend_rs1),
    .rf_rdata (rf_rdata1),
    .lw_we    (lw.we),
    .lw_waddr (lw.waddr),
    .lw_wdata (lw.wdata),
    .val      (res1),
    .hit      (hit1)
  );

  operand_resolve u_res2 (
    .rs       (pend_rs2),
    .rf_rdata (rf_rdata2),
    .lw_we    (lw.we),
    .lw_waddr (lw.waddr),
    .lw_wdata (lw.wdata),
    .val      (res2),
    .hit      (hit2)
  );

`ifdef OPFETCH_BYPASS_EN
  logic unused_hits;
  assign unused_hits = hit1 | hit2;
  assign pend_hold   = 1'b0;
`else
  // The read data is stale on a hit; stay in PEND and re-read next cycle.
  assign pend_hold = pend_valid && (hit1 || hit2);
`endif

  assign pend_advances = pend_valid && !pend_hold && (!out_valid || out_ready);
  assign in_ready      = !rst && (!pend_valid || pend_advances);
  assign accepting     = in_valid && in_ready;

  // A stalled PEND keeps re-reading its own sources so the data stays current.
  assign rf_raddr1 = rst ? '0 : (accepting ? in_rs1 : pend_rs1);
  assign rf_raddr2 = rst ? '0 : (accepting ? in_rs2 : pend_rs2);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid   <= 1'b0;
      pend_rs1     <= '0;
      pend_rs2     <= '0;
      pend_payload <= '0;
      lw           <= '0;
    end else begin
      lw <= '{we: wb_we, waddr: wb_waddr, wdata: wb_wdata};
      if (accepting) begin
        pend_valid   <= 1'b1;
        pend_rs1     <= in_rs1;
        pend_rs2     <= in_rs2;
        pend_payload <= in_payload;
      end else if (pend_advances) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // A write committing on the same edge the operands move into OUT is not yet
  // visible to PEND's resolution, so it is folded in on load as well as while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_payload <= '0;
    end else if (pend_advances) begin
      out_valid   <= 1'b1;
      out_rs1     <= pend_rs1;
      out_rs2     <= pend_rs2;
      out_payload <= pend_payload;
      out_rs1_val <= wb_hit(wb_we, wb_waddr, pend_rs1) ? wb_wdata : res1;
      out_rs2_val <= wb_hit(wb_we, wb_waddr, pend_rs2) ? wb_wdata : res2;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (wb_hit(wb_we, wb_waddr, out_rs1)) out_rs1_val <= wb_wdata;
      if (wb_hit(wb_we, wb_waddr, out_rs2)) out_rs2_val <= wb_wdata;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file
// (registered reads, pre-write data on a shared edge, x0 hard-wired).
// Inputs are driven 1 time unit after the rising edge; outputs are checked on the
// falling edge.
module tb_operand_fetch;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int PW   = 64;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rs1;
  logic [AW-1:0]   in_rs2;
  logic [PW-1:0]   in_payload;
  logic [AW-1:0]   rf_raddr1;
  logic [AW-1:0]   rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic            wb_we;
  logic [AW-1:0]   wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [PW-1:0]   out_payload;

  logic [XLEN-1:0] rf [32];

  int total = 0;
  int bad   = 0;

`ifdef OPFETCH_BYPASS_EN
  localparam int HAZ_EXTRA = 0;
`else
  localparam int HAZ_EXTRA = 1;
`endif

  operand_fetch #(.PW(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_payload  (in_payload),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val),
    .out_payload (out_payload)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] init_val(input int i);
    case (i)
      1:       return 32'd5;
      2:       return 32'd7;
      3:       return 32'h11;
      4:       return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // register file model: preloaded while in reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
      rf_rdata1 <= '0;
      rf_rdata2 <= '0;
    end else begin
      rf_rdata1 <= rf[rf_raddr1];
      rf_rdata2 <= rf[rf_raddr2];
      if (wb_we && wb_waddr != '0) rf[wb_waddr] <= wb_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [PW-1:0] p);
    in_valid   = 1'b1;
    in_rs1     = r1;
    in_rs2     = r2;
    in_payload = p;
  endtask

  task automatic wb(input logic we, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wb_we    = we;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    out_ready = 1'b1;
    send(5'd1, 5'd2, 64'hdead);
    wb(1'b0, '0, '0);

    // reset with in_valid high
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rs1_val", out_rs1_val, 0);
    check("rst_rs2_val", out_rs2_val, 0);
    check("rst_payload", out_payload, 0);
    check("rst_raddr1", rf_raddr1, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // streaming (1,2),(2,1),(0,1)
    tick();
    send(5'd1, 5'd2, 64'hA0);
    @(negedge clk);
    check("str_in_ready", in_ready, 1);
    tick();
    send(5'd2, 5'd1, 64'hB0);
    @(negedge clk);
    check("str_lat_n1", out_valid, 0);
    tick();
    send(5'd0, 5'd1, 64'hC0);
    @(negedge clk);
    check("str_a_valid", out_valid, 1);
    check("str_a_rs1", out_rs1_val, 5);
    check("str_a_rs2", out_rs2_val, 7);
    check("str_a_pay", out_payload, 64'hA0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("str_b_valid", out_valid, 1);
    check("str_b_rs1", out_rs1_val, 7);
    check("str_b_rs2", out_rs2_val, 5);
    check("str_b_pay", out_payload, 64'hB0);
    tick();
    @(negedge clk);
    check("str_c_valid", out_valid, 1);
    check("str_c_rs1", out_rs1_val, 0);
    check("str_c_rs2", out_rs2_val, 5);
    check("str_c_pay", out_payload, 64'hC0);
    tick();
    @(negedge clk);
    check("str_drain", out_valid, 0);

    // same-edge hazard: accept rs1=3 while x3 <= 0xAA
    tick();
    send(5'd3, 5'd1, 64'hD0);
    wb(1'b1, 5'd3, 32'hAA);
    tick();
    in_valid = 1'b0;
    wb(1'b0, '0, '0);
    tick();
    @(negedge clk);
    check("haz_n2_valid", out_valid, (HAZ_EXTRA == 0) ? 1 : 0);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    check("haz_valid", out_valid, 1);
    check("haz_extra_cycles", waited, HAZ_EXTRA);
    check("haz_rs1", out_rs1_val, 32'hAA);
    check("haz_rs2", out_rs2_val, 5);
    check("haz_pay", out_payload, 64'hD0);
    tick();
    @(negedge clk);
    check("haz_drain", out_valid, 0);

    // backpressure snoop: OUT holds rs2=4 (1), then x4 <= 0x55
    tick();
    out_ready = 1'b0;
    send(5'd1, 5'd4, 64'hE0);
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("bp_rs1", out_rs1_val, 5);
    check("bp_rs2_before", out_rs2_val, 1);
    tick();
    wb(1'b1, 5'd4, 32'h55);
    @(negedge clk);
    check("bp_rs2_same_cycle", out_rs2_val, 1);
    tick();
    wb(1'b0, '0, '0);
    @(negedge clk);
    check("bp_rs2_after", out_rs2_val, 32'h55);
    check("bp_rs1_after", out_rs1_val, 5);
    check("bp_pay", out_payload, 64'hE0);
    check("bp_valid", out_valid, 1);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_drain", out_valid, 0);

    // x0 write while rs1=0 sits in both PEND and OUT
    tick();
    out_ready = 1'b0;
    send(5'd0, 5'd1, 64'hF0);
    tick();
    send(5'd0, 5'd2, 64'hF1);
    wb(1'b1, 5'd0, 32'hFF);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("x0_in_ready", in_ready, 0);
    tick();
    @(negedge clk);
    check("x0_out_rs1", out_rs1_val, 0);
    check("x0_out_rs2", out_rs2_val, 5);
    check("x0_out_pay", out_payload, 64'hF0);
    check("x0_stall_raddr2", rf_raddr2, 2);
    tick();
    wb(1'b0, '0, '0);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("x0_pend_rs1", out_rs1_val, 0);
    check("x0_pend_rs2", out_rs2_val, 7);
    check("x0_pend_pay", out_payload, 64'hF1);
    tick();
    @(negedge clk);
    check("x0_drain", out_valid, 0);

    // reset mid-flight with two instructions in PEND and OUT
    tick();
    out_ready = 1'b0;
    send(5'd1, 5'd2, 64'h11);
    tick();
    send(5'd2, 5'd2, 64'h22);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_setup_valid", out_valid, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_valid", out_valid, 0);
    check("mid_pay", out_payload, 0);
    check("mid_rs1", out_rs1_val, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("mid_no_emit", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
